matrix_sum_serializer: RTL
==========================

# matrix_sum_serializer

Downstream consumer of the 12×10 matrix-add stage. It captures the full (IN_WIDTH+1)-bit sum matrix in one cycle when the adder signals output ready, then streams it one element per handshake over a valid/ready interface. Each element is saturated back to IN_WIDTH bits on the way out. The block also tracks position in the matrix, flags saturation, and flags any sum matrix that arrives while the previous one is still draining.

## Interface
- IN_WIDTH, 16, adder input width; sums arrive as IN_WIDTH+1 signed, leave as IN_WIDTH signed
- VEC_LEN, 10, elements per vector
- NUM_VEC, 12, vectors per matrix
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- enable  in  1  global advance enable; low freezes all registers
- sumReady  in  1  one-cycle pulse from adder (V0toV11outReady)
- sumBus  in  NUM_VEC*VEC_LEN*(IN_WIDTH+1)  packed sums; element e of vector v at bit offset (v*VEC_LEN+e)*(IN_WIDTH+1), signed
- outValid  out  1  element on outData is valid
- outReady  in  1  downstream accepts
- outData  out  IN_WIDTH  saturated element, signed
- outSat  out  1  current element was clipped
- outElem  out  clog2(VEC_LEN)  element index e of current output
- outVec  out  clog2(NUM_VEC)  vector index v of current output
- outLastElem  out  1  e == VEC_LEN-1
- outLastMatrix  out  1  e == VEC_LEN-1 and v == NUM_VEC-1
- busy  out  1  matrix held, not fully drained
- overrun  out  1  sticky; sumReady arrived while busy and could not be captured

## Operation
- States: IDLE, STREAM. The busy output equals state==STREAM.
- A handshake is enable & outValid & outReady.
- IDLE, enable=1, sumReady=1: capture all of sumBus into the internal buffer. Set e=0, v=0. Go to STREAM.
- STREAM, on each handshake: if e<VEC_LEN-1 then e++. Otherwise set e=0 and v++.
- The handshake on the last element (e=VEC_LEN-1, v=NUM_VEC-1) ends the matrix:
  - with sumReady=1 in the same cycle: capture the new matrix, reset indices to 0, stay in STREAM (back-to-back, no bubble);
  - otherwise go to IDLE.
- sumReady=1 in STREAM without a last-element handshake: the new matrix is ignored and overrun is set to 1. overrun clears only on reset.
- enable=0: state, indices, buffer and overrun hold. sumReady is ignored and does not set overrun. outValid is forced to 0.
- Output generation:
  - outValid = (state==STREAM) & enable.
  - outData, outSat, outLast* come from a combinational mux on the buffer at (v,e).
  - These outputs are stable while outValid=1 and outReady=0.
- Saturation of a sum S:
  - S > 2^(IN_WIDTH-1)-1 gives 2^(IN_WIDTH-1)-1 with outSat=1;
  - S < -2^(IN_WIDTH-1) gives -2^(IN_WIDTH-1) with outSat=1;
  - otherwise S[IN_WIDTH-1:0] with outSat=0.
- In IDLE, outData/outSat reflect buffer(0,0) and are don't-care for consumers.

## Timing
- Reset values (reset low): state IDLE, buffer all 0, e=0, v=0, outValid 0, outData 0, outSat 0, outLastElem 0, outLastMatrix 0, busy 0, overrun 0.
- Reset is asynchronous on assertion and released synchronously into the design.
- Latency: sumReady sampled high at edge N gives outValid=1 with element (0,0) after edge N.
- Throughput: one element per cycle while outReady=1. A full matrix drains in VEC_LEN*NUM_VEC = 120 handshake cycles minimum.
- outReady may toggle arbitrarily. There is no combinational path from outReady to outValid.
- Reset asserted mid-stream aborts the stream at once. The partially sent matrix is discarded and outValid drops asynchronously.
- Simultaneous last-element handshake and sumReady is the only legal capture point while busy.

## Test plan
- Capture and stream: load sumBus with S(v,e)=v*100+e, pulse sumReady, hold outReady=1 → outValid high 1 cycle later. Expect 120 consecutive elements 0,1,…,9,100,…,1109. outLastElem on every 10th; outLastMatrix only on 1109; busy falls after it.
- Saturation (IN_WIDTH=16): sums 40000, -40000, 32767, -32768, 1234 → outData 32767/-32768/32767/-32768/1234 with outSat 1/1/0/0/0.
- Backpressure: outReady random 50%, plus enable low for 5 cycles mid-stream → outValid=0 while enable low. No element skipped or duplicated; outData stable during every stall; sequence identical to the first scenario.
- Back-to-back: pulse sumReady exactly on the last-element handshake with a second matrix → element (0,0) of the new matrix on the next cycle, no bubble, overrun stays 0.
- Overrun: pulse sumReady at element 57 → it is ignored. overrun=1 and stays 1; the stream continues with the original data to 120 elements, and overrun persists through IDLE until reset.
- Reset mid-stream: assert reset at element 30 → outValid, busy, overrun go to 0 immediately. After release, a new sumReady restarts at (0,0).

Source files
------------

// File: rtl/matrix_sum_serializer.sv
// matrix_sum_serializer
//   Captures the full (IN_WIDTH+1)-bit sum matrix from the matrix-add stage in
//   one cycle when sumReady pulses. It then streams the matrix one element per
//   valid/ready handshake, in order e=0..VEC_LEN-1 within v=0..NUM_VEC-1, with
//   each element saturated to IN_WIDTH bits.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low reset (assert async, release sync)
//   enable        global advance enable; low freezes all state, forces outValid=0
//   sumReady      one-cycle capture pulse from the adder
//   sumBus        packed sums, element (v,e) at bit (v*VEC_LEN+e)*(IN_WIDTH+1)
//   outValid      element on outData is valid
//   outReady      downstream accepts
//   outData       saturated element (signed)
//   outSat        current element was clipped
//   outElem       element index e of current output
//   outVec        vector index v of current output
//   outLastElem   e == VEC_LEN-1
//   outLastMatrix last element of the matrix
//   busy          matrix held, not fully drained
//   overrun       sticky: sumReady arrived while busy and was dropped
module matrix_sum_serializer #(
  parameter int IN_WIDTH = 16,
  parameter int VEC_LEN  = 10,
  parameter int NUM_VEC  = 12,
  localparam int ELEM_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1,
  localparam int VEC_W   = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        enable,
  input  logic                                        sumReady,
  input  logic [NUM_VEC*VEC_LEN*(IN_WIDTH+1)-1:0]     sumBus,
  output logic                                        outValid,
  input  logic                                        outReady,
  output logic [IN_WIDTH-1:0]                         outData,
  output logic                                        outSat,
  output logic [ELEM_W-1:0]                           outElem,
  output logic [VEC_W-1:0]                            outVec,
  output logic                                        outLastElem,
  output logic                                        outLastMatrix,
  output logic                                        busy,
  output logic                                        overrun
);

  localparam int NUM_EL = NUM_VEC * VEC_LEN;
  localparam int SUM_W  = IN_WIDTH + 1;
  localparam int IDX_W  = (NUM_EL > 1) ? $clog2(NUM_EL) : 1;
  localparam logic [ELEM_W-1:0] LAST_E = ELEM_W'(VEC_LEN - 1);
  localparam logic [VEC_W-1:0]  LAST_V = VEC_W'(NUM_VEC - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t              state, stateNext;
  logic [1:0]          rstSync;
  logic                rstN;
  logic [ELEM_W-1:0]   elem, elemNext;
  logic [VEC_W-1:0]    vec, vecNext;
  logic                overrunNext;
  logic                capture;
  logic                handshake;
  logic                lastElem;
  logic                lastMatrix;
  logic [IDX_W-1:0]    idx;
  logic [SUM_W-1:0]    cur;
  logic [SUM_W-1:0]    buffer [NUM_EL];

  // Reset asserts asynchronously through the synchronizer flops and is
  // released two edges later, so the design leaves reset cleanly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rstSync <= '0;
    else        rstSync <= {rstSync[0], 1'b1};
  end

  assign rstN = rstSync[1];

  assign lastElem   = (elem == LAST_E);
  assign lastMatrix = lastElem && (vec == LAST_V);
  assign outValid   = (state == STREAM) && enable;
  assign handshake  = outValid && outReady;
  assign busy       = (state == STREAM);

  // Next-state / index / capture logic
  always_comb begin
    stateNext   = state;
    elemNext    = elem;
    vecNext     = vec;
    overrunNext = overrun;
    capture     = 1'b0;
    if (enable) begin
      case (state)
        IDLE: begin
          if (sumReady) begin
            capture   = 1'b1;
            elemNext  = '0;
            vecNext   = '0;
            stateNext = STREAM;
          end
        end
        STREAM: begin
          if (handshake) begin
            if (lastMatrix) begin
              // Indices return to (0,0) either for the back-to-back matrix or
              // so that IDLE presents buffer(0,0).
              elemNext = '0;
              vecNext  = '0;
              if (sumReady) capture = 1'b1;
              else          stateNext = IDLE;
            end else if (!lastElem) begin
              elemNext = elem + 1'b1;
            end else begin
              elemNext = '0;
              vecNext  = vec + 1'b1;
            end
          end
          if (sumReady && !(handshake && lastMatrix)) overrunNext = 1'b1;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= IDLE;
      elem    <= '0;
      vec     <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= stateNext;
      elem    <= elemNext;
      vec     <= vecNext;
      overrun <= overrunNext;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int unsigned i = 0; i < NUM_EL; i++) buffer[IDX_W'(i)] <= '0;
    end else if (capture) begin
      for (int unsigned i = 0; i < NUM_EL; i++)
        buffer[IDX_W'(i)] <= sumBus[i*SUM_W +: SUM_W];
    end
  end

  // Output mux and saturation
  assign idx = IDX_W'(vec) * IDX_W'(VEC_LEN) + IDX_W'(elem);
  assign cur = buffer[idx];

  always_comb begin
    outSat  = 1'b0;
    outData = cur[IN_WIDTH-1:0];
    // The sum fits in IN_WIDTH bits exactly when its top two bits agree.
    if (cur[IN_WIDTH] != cur[IN_WIDTH-1]) begin
      outSat  = 1'b1;
      outData = cur[IN_WIDTH] ? {1'b1, {(IN_WIDTH-1){1'b0}}}
                              : {1'b0, {(IN_WIDTH-1){1'b1}}};
    end
  end

  assign outElem       = elem;
  assign outVec        = vec;
  assign outLastElem   = lastElem;
  assign outLastMatrix = lastMatrix;

endmodule
